cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Round-robin arbiter that shares the single common data bus (CDB) among the out-of-order core's result producers: ALU, LSB load return and branch/jump unit.
- Producers present a completed result (RoB index and value) with a valid/ready handshake. The arbiter grants one per cycle and drives a registered CDB broadcast to the RoB, the RS, the LSB and the register-file dependency logic.
- On a RoB clear (misprediction flush) the arbiter drops its pending broadcast.

Parameters:
- N_REQ, 3, number of requesters (index 0 = ALU, 1 = LSB, 2 = branch unit)
- ROB_W, `ROB_SIZE_WIDTH, width of a RoB index
- DATA_W, 32, width of the result value
- SRC_W, 2, width of the source index; must satisfy 2^SRC_W >= N_REQ

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low freezes the block
- flush  in  1  RoB clear; discards current arbitration
- req_valid  in  N_REQ  per-requester result valid
- req_rob_id  in  N_REQ*ROB_W  packed RoB indices; requester i occupies bits [i*ROB_W +: ROB_W]
- req_value  in  N_REQ*DATA_W  packed result values; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  N_REQ  one-hot grant, combinational
- cdb_valid  out  1  broadcast valid, registered
- cdb_rob_id  out  ROB_W  broadcast RoB index, registered
- cdb_value  out  DATA_W  broadcast value, registered
- cdb_src  out  SRC_W  index of the granted requester, registered

Behaviour:
- Priority order: rst > !rdy > flush > normal operation.
- Reset:
  - cdb_valid, cdb_rob_id, cdb_value and cdb_src all go to 0.
  - Round-robin pointer rr_ptr goes to 0, so requester 0 has highest priority.
  - req_ready is 0 while rst is high.
- rdy low:
  - req_ready is all 0.
  - All registers, including rr_ptr and the cdb_* outputs, hold their values.
- flush high (with rdy high):
  - req_ready is all 0.
  - Next cycle cdb_valid = 0; the other cdb_* fields and rr_ptr hold.
  - Requesters discard their own in-flight results.
- Grant rule:
  - g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[g] = 1 combinationally in the same cycle; all other bits are 0.
  - At most one bit of req_ready is high.
- Handshake: a transfer occurs at a posedge where req_valid[i] && req_ready[i]. Requesters hold valid, rob_id and value stable until the transfer.
- Latency: a request granted in cycle t appears on the CDB in cycle t+1.
  - cdb_valid = 1; cdb_rob_id, cdb_value and cdb_src = g.
  - rr_ptr <= (g+1) mod N_REQ, wrapping N_REQ-1 to 0.
- No valid requester:
  - Next cycle cdb_valid = 0.
  - cdb_rob_id, cdb_value, cdb_src and rr_ptr hold.
- cdb_valid is a one-cycle pulse per grant. Back-to-back grants in consecutive cycles are supported, giving a throughput of one result per cycle.
- A single requester asserting continuously is granted every cycle.
- Fairness: a continuously valid requester is granted within N_REQ cycles, excluding cycles with flush or rdy low.
- req_valid deasserting before its grant is legal and is not treated as an error.
- Simultaneous flush and req_valid: flush wins, and no grant is issued that cycle.

Optional Feature:
- Macro: CDB_PERF_EN.
- Defined:
  - Adds output perf_stall, N_REQ*32 bits, packed per requester.
  - Counter i increments in each cycle where rdy && !rst && req_valid[i] && !req_ready[i]. Flush cycles count.
  - Counters saturate at 32'hFFFFFFFF and reset to 0.
- Not defined: the port and the counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then idle -> cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_src=0 and req_ready=0 every cycle.
- Only requester 1 valid in cycle t with rob_id=5, value=32'hDEADBEEF -> req_ready=3'b010 in t. In t+1: cdb_valid=1, cdb_rob_id=5, cdb_value=32'hDEADBEEF, cdb_src=1. In t+2: cdb_valid=0.
- All three requesters valid continuously from reset for 6 cycles -> cdb_src sequence 0,1,2,0,1,2 with cdb_valid=1 each cycle. With CDB_PERF_EN, every perf_stall counter = 4.
- Requesters 0 and 2 valid with rr_ptr=1 -> grant order 2 then 0. rr_ptr wraps to 0 and then to 1.
- All three valid, flush high for one cycle after the grant to requester 0:
  - req_ready=0 that cycle.
  - Next cycle cdb_valid=0.
  - Then requester 1 is granted, showing rr_ptr was unchanged by the flush.
- rdy low for 3 cycles mid-stream with requester 2 valid -> req_ready=0 and the cdb_* outputs are frozen. Once rdy returns high, the grant resumes in the same order.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result handshake from producers plus the registered CDB broadcast
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif
interface cdb_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ROB_W  = `ROB_SIZE_WIDTH,
    parameter int DATA_W = 32,
    parameter int SRC_W  = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ROB_W-1:0]  req_rob_id;
    logic [N_REQ*DATA_W-1:0] req_value;
    logic [N_REQ-1:0]        req_ready;
    logic                    cdb_valid;
    logic [ROB_W-1:0]        cdb_rob_id;
    logic [DATA_W-1:0]       cdb_value;
    logic [SRC_W-1:0]        cdb_src;

    modport master (
        output req_valid, req_rob_id, req_value,
        input  req_ready, cdb_valid, cdb_rob_id, cdb_value, cdb_src
    );

    modport slave (
        input  req_valid, req_rob_id, req_value,
        output req_ready, cdb_valid, cdb_rob_id, cdb_value, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of the common data bus; CDB_PERF_EN adds per-requester stall counters on perf_stall
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 5
`endif
module cdb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ROB_W  = `ROB_SIZE_WIDTH,
    parameter int DATA_W = 32,
    parameter int SRC_W  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
`ifdef CDB_PERF_EN
    output logic [N_REQ*32-1:0] perf_stall,
`endif
    cdb_arbiter_if.slave        bus
);
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  g;
    logic              hit;
    logic [ROB_W-1:0]  sel_rob_id;
    logic [DATA_W-1:0] sel_value;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        hit = 1'b0;
        g   = '0;
        for (int k = 0; k < N_REQ; k++)
            for (int i = 0; i < N_REQ; i++)
                if (!hit && bus.req_valid[i] && (int'(rr_ptr) + k) % N_REQ == i) begin
                    hit = 1'b1;
                    g   = SRC_W'(i);
                end
    end

    // Route the winner's payload toward the broadcast register
    always_comb begin
        sel_rob_id = '0;
        sel_value  = '0;
        for (int i = 0; i < N_REQ; i++)
            if (g == SRC_W'(i)) begin
                sel_rob_id = bus.req_rob_id[i*ROB_W +: ROB_W];
                sel_value  = bus.req_value[i*DATA_W +: DATA_W];
            end
    end

    assign bus.req_ready = (rst || !rdy || flush || !hit) ? '0 : N_REQ'(1) << g;

    // Registered broadcast and pointer; flush only kills the pulse, payload and pointer hold
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cdb_valid  <= 1'b0;
            bus.cdb_rob_id <= '0;
            bus.cdb_value  <= '0;
            bus.cdb_src    <= '0;
            rr_ptr         <= '0;
        end else if (rdy) begin
            if (flush || !hit) begin
                bus.cdb_valid <= 1'b0;
            end else begin
                bus.cdb_valid  <= 1'b1;
                bus.cdb_rob_id <= sel_rob_id;
                bus.cdb_value  <= sel_value;
                bus.cdb_src    <= g;
                rr_ptr         <= (g == SRC_W'(N_REQ - 1)) ? '0 : g + 1'b1;
            end
        end
    end

`ifdef CDB_PERF_EN
    logic [31:0] stall [N_REQ];

    // Saturating count of cycles each requester waited while the core was running
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) stall[i] <= '0;
        end else if (rdy) begin
            for (int i = 0; i < N_REQ; i++)
                if (bus.req_valid[i] && !bus.req_ready[i] && stall[i] != '1)
                    stall[i] <= stall[i] + 32'd1;
        end
    end

    // Flatten the counters onto the packed port
    always_comb begin
        perf_stall = '0;
        for (int i = 0; i < N_REQ; i++) perf_stall[i*32 +: 32] = stall[i];
    end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random stimulus against a cycle-level model of the CDB arbiter
module tb_cdb_arbiter;
    localparam int N  = 3;
    localparam int RW = 5;
    localparam int DW = 32;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst, rdy, flush;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_REQ(N), .ROB_W(RW), .DATA_W(DW), .SRC_W(SW)) bus ();
`ifdef CDB_PERF_EN
    logic [N*32-1:0] perf_stall;
`endif

    cdb_arbiter #(.N_REQ(N), .ROB_W(RW), .DATA_W(DW), .SRC_W(SW)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .flush(flush),
`ifdef CDB_PERF_EN
        .perf_stall(perf_stall),
`endif
        .bus(bus.slave)
    );

    int total = 0;
    int bad = 0;

    int          m_rr;
    logic        m_v;
    logic [RW-1:0] m_rob;
    logic [DW-1:0] m_val;
    logic [SW-1:0] m_src;
    logic [31:0] m_st [N];

    function automatic int pick(logic [N-1:0] v, int rr);
        for (int k = 0; k < N; k++)
            if (v[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(int i, logic v, logic [RW-1:0] rob, logic [DW-1:0] val);
        bus.req_valid[i] = v;
        bus.req_rob_id[i*RW +: RW] = rob;
        bus.req_value[i*DW +: DW] = val;
    endtask

    task automatic cyc();
        int g;
        logic [N-1:0] er;
        #1;
        g = pick(bus.req_valid, m_rr);
        er = (rst || !rdy || flush || g < 0) ? '0 : N'(1) << g;
        chk("req_ready", 128'(bus.req_ready), 128'(er));
        @(posedge clk);
        if (rst) begin
            m_v = 0; m_rob = 0; m_val = 0; m_src = 0; m_rr = 0;
            for (int i = 0; i < N; i++) m_st[i] = 0;
        end else if (rdy) begin
            for (int i = 0; i < N; i++)
                if (bus.req_valid[i] && !er[i] && m_st[i] != 32'hFFFFFFFF) m_st[i]++;
            if (flush || g < 0) m_v = 0;
            else begin
                m_v = 1;
                m_rob = bus.req_rob_id[g*RW +: RW];
                m_val = bus.req_value[g*DW +: DW];
                m_src = SW'(g);
                m_rr = (g + 1) % N;
            end
        end
        #1;
        chk("cdb_valid", 128'(bus.cdb_valid), 128'(m_v));
        chk("cdb_rob_id", 128'(bus.cdb_rob_id), 128'(m_rob));
        chk("cdb_value", 128'(bus.cdb_value), 128'(m_val));
        chk("cdb_src", 128'(bus.cdb_src), 128'(m_src));
`ifdef CDB_PERF_EN
        chk("perf_stall", 128'(perf_stall), 128'({m_st[2], m_st[1], m_st[0]}));
`endif
        @(negedge clk);
    endtask

    initial begin
        rst = 1; rdy = 1; flush = 0;
        bus.req_valid = '0; bus.req_rob_id = '0; bus.req_value = '0;
        m_rr = 0; m_v = 0; m_rob = 0; m_val = 0; m_src = 0;
        for (int i = 0; i < N; i++) m_st[i] = 0;
        @(negedge clk);
        bus.req_valid = 3'b111;
        cyc(); cyc();
        rst = 0; bus.req_valid = '0;
        repeat (3) cyc();

        set_req(1, 1, 5'd5, 32'hDEADBEEF);
        cyc();
        bus.req_valid = '0;
        cyc(); cyc();

        rst = 1; cyc(); rst = 0;
        set_req(0, 1, 5'd1, 32'h1111_0000);
        set_req(1, 1, 5'd2, 32'h2222_0000);
        set_req(2, 1, 5'd3, 32'h3333_0000);
        repeat (6) cyc();

        bus.req_valid = 3'b001; cyc();
        bus.req_valid = 3'b101; cyc(); cyc();
        bus.req_valid = '0; cyc();

        bus.req_valid = 3'b001; cyc();
        bus.req_valid = 3'b111; flush = 1; cyc();
        flush = 0; cyc();
        bus.req_valid = '0; cyc();

        bus.req_valid = 3'b111; cyc(); cyc();
        rdy = 0; bus.req_valid = 3'b100;
        repeat (3) cyc();
        rdy = 1; bus.req_valid = 3'b111;
        repeat (3) cyc();

        repeat (400) begin
            rst = ($urandom % 100) == 0;
            rdy = ($urandom % 10) != 0;
            flush = ($urandom % 20) == 0;
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom), RW'($urandom), $urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
